spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI peripheral-side (slave) endpoint. Receives MOSI bytes from the on-chip SPI master and returns MISO bytes through a one-entry transmit holding buffer.
- Runs entirely in the system clk domain. sclk, cs_n and mosi are oversampled through synchronizers.
- Mode 0 (CPOL=0, CPHA=0), MSB first, fixed-length words.
- Sits behind one chip-select line of the master and presents a valid/ready byte interface to local logic.

Parameters:
- DATA_W, 8: bits per SPI word; also the width of tx_data and rx_data.
- SYNC_STAGES, 2: flip-flop stages on each of sclk, cs_n and mosi. Minimum 2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sclk  in  1  SPI clock from master, asynchronous to clk
- cs_n  in  1  chip select from master, active low
- mosi  in  1  serial data from master
- miso  out  1  serial data to master
- tx_data  in  DATA_W  next word to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  holding buffer empty; a word is accepted when tx_valid && tx_ready
- rx_data  out  DATA_W  last complete received word; held until the next word completes
- rx_valid  out  1  one-clk pulse when rx_data updates
- busy  out  1  synchronized cs_n is low
- frame_err  out  1  one-clk pulse: cs_n rose mid-word
- tx_underrun  out  1  one-clk pulse: a word load was needed but the buffer was empty

Behaviour:
- Reset (reset_n low, asynchronous): all registers clear; state is IDLE.
  - miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, frame_err=0, tx_underrun=0.
- Synchronizers: each input passes through SYNC_STAGES flops, plus one previous-value flop used for edge detection.
  - A pin event is acted on SYNC_STAGES+1 clk cycles after it occurs.
  - Required: sclk high and low phases each ≥ SYNC_STAGES+2 clk cycles.
- TX holding buffer: one entry.
  - Accepting a word sets buf_full, so tx_ready=0.
  - Loading the word into the tx shifter clears buf_full.
  - Accept and load in the same cycle: the load takes the old buffer contents and the new word lands in the buffer, so buf_full stays 1.
- State machine, two states:
  - IDLE → SHIFT on synced cs_n falling edge.
    - Load tx shifter from the buffer, or from all-zeros if the buffer is empty; an empty buffer also pulses tx_underrun.
    - miso = shifter MSB.
    - bit_cnt = 0.
  - SHIFT, sclk rising edge:
    - rx_shift = {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++.
    - When bit_cnt reaches DATA_W: rx_data = assembled word, rx_valid pulse, bit_cnt = 0, word_done = 1.
  - SHIFT, sclk falling edge:
    - word_done = 1: load the next word (same rules as at cs_n fall), clear word_done, miso = new MSB.
    - Otherwise: shift tx left, miso = next bit.
  - SHIFT → IDLE on synced cs_n rising edge.
    - bit_cnt ≠ 0: pulse frame_err and discard the partial rx word; rx_data is unchanged and there is no rx_valid.
    - bit_cnt = 0: end quietly.
    - In both cases miso returns to 0 and bit_cnt, word_done and the tx shifter clear. An unconsumed holding buffer is kept.
- Simultaneous cs_n rise and sclk edge in the same cycle: cs_n wins and the sclk edge is ignored.
- sclk edges while in IDLE are ignored.
- Back-to-back words inside one cs_n assertion are supported. An rx_valid pulse follows every DATA_W rising edges.
- Latency: rx_valid asserts SYNC_STAGES+1 clk cycles after the final sclk rising edge of a word.
- Reset mid-frame aborts the frame immediately with no error pulse.

Optional Feature:
- Macro SPI_SLAVE_MISO_OE_EN.
- Defined: adds output port miso_oe (1 bit).
  - miso_oe = 1 while in SHIFT, 0 in IDLE and at reset.
  - miso is unchanged; the top level uses miso_oe to tri-state the shared MISO line.
- Undefined: no miso_oe port; miso is always driven, and is 0 while idle.

Test Plan:
- Single word: preload tx_data=0xA5, then master sends 0x3C with sclk half-period 10 clk. Required: miso bit sequence 1,0,1,0,0,1,0,1; rx_data=0x3C; exactly one rx_valid pulse; tx_ready returns to 1 at the cs_n fall.
- Back-to-back: buffer 0x81, then 0x7E offered after the first load; master sends 0x11 and 0x22 under one cs_n. Required: miso returns 0x81 then 0x7E; rx_valid pulses twice with 0x11 then 0x22; no tx_underrun.
- Underrun: no tx word offered, master sends 0xF0. Required: tx_underrun pulses at the cs_n fall; miso is all zeros; rx_data=0xF0.
- Aborted frame: cs_n rises after 5 sclk rising edges. Required: frame_err pulses once; no rx_valid; rx_data keeps its previous value; the next full frame is received correctly.
- Async reset mid-frame: reset_n low after 3 bits, then released, then a full frame 0x5A. Required: all outputs at reset values while reset_n is low; no frame_err; the next frame yields rx_data=0x5A.
- SPI_SLAVE_MISO_OE_EN defined: miso_oe rises SYNC_STAGES+1 clk after cs_n falls and falls SYNC_STAGES+1 clk after cs_n rises; it is 0 throughout reset.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 peripheral endpoint, MSB first, one-entry TX holding buffer, byte valid/ready to local logic.
// Latency: pin events act SYNC_STAGES+1 clk later; rx_valid fires SYNC_STAGES+1 clk after the last sclk rise of a word.
// Backpressure: tx_ready low while the holding buffer is full; the rx side cannot stall (rx_data held until next word).
// Optional build macro SPI_SLAVE_MISO_OE_EN adds a miso_oe output for tri-stating a shared MISO line.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic              miso_oe,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              tx_underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state;

  // Synchronizer chains; the last stage of each is the "synced" pin value.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;
  logic                   cs_fall;

  // Holding buffer between local logic and the tx shifter.
  logic                   buf_full;
  logic [DATA_W-1:0]      buf_data;

  // The tx MSB lives in miso itself, so only the remaining bits are kept here.
  logic [DATA_W-2:0]      tx_rest;
  // Only DATA_W-1 bits need storing: the last bit comes straight from mosi_s.
  logic [DATA_W-2:0]      rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   word_done;

  logic                   load_now;
  logic                   accept;
  logic [DATA_W-1:0]      load_word;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  assign cs_fall   = ~cs_s & cs_prev;

  // A word load happens at frame start and on the sclk fall that follows a completed word;
  // a simultaneous cs_n rise suppresses the latter.
  assign load_now  = ((state == IDLE) && cs_fall) ||
                     ((state == SHIFT) && !cs_rise && sclk_fall && word_done);
  assign accept    = tx_valid && !buf_full;
  assign load_word = buf_full ? buf_data : '0;

  assign tx_ready  = !buf_full;
  assign busy      = !cs_s;

  // Oversample the SPI pins. cs_n chain resets to its idle (high) level so that
  // reset release is not mistaken for a chip-select assertion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // Holding buffer: accept wins over load so a same-cycle accept leaves the buffer full,
  // while the load itself uses the pre-accept contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= tx_data;
    end else if (load_now) begin
      buf_full <= 1'b0;
    end
  end

  // Frame state machine: shifting, word assembly, status pulses and miso drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      tx_rest     <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      miso        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
      miso_oe     <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      tx_underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= SHIFT;
            miso        <= load_word[DATA_W-1];
            tx_rest     <= load_word[DATA_W-2:0];
            tx_underrun <= !buf_full;
            bit_cnt     <= '0;
            word_done   <= 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
            miso_oe     <= 1'b1;
`endif
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            // A partial word is dropped; rx_data keeps the last complete word.
            state     <= IDLE;
            frame_err <= (bit_cnt != '0);
            miso      <= 1'b0;
            tx_rest   <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
`ifdef SPI_SLAVE_MISO_OE_EN
            miso_oe   <= 1'b0;
`endif
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              rx_data   <= {rx_shift, mosi_s};
              rx_valid  <= 1'b1;
              bit_cnt   <= '0;
              word_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            if (word_done) begin
              miso        <= load_word[DATA_W-1];
              tx_rest     <= load_word[DATA_W-2:0];
              tx_underrun <= !buf_full;
              word_done   <= 1'b0;
            end else begin
              miso    <= tx_rest[DATA_W-2];
              tx_rest <= {tx_rest[DATA_W-3:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: drives an SPI mode-0 master and a tx producer, scoreboards rx words and status pulses.
// Reference: words queue in/out in order; every word slot consumes one offered tx word or underruns.
module tb_spi_slave;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sclk = 1'b0;
  logic              cs_n = 1'b1;
  logic              mosi = 1'b0;
  logic              miso;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic              miso_oe;
`endif
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              frame_err;
  logic              tx_underrun;

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .mosi       (mosi),
    .miso       (miso),
`ifdef SPI_SLAVE_MISO_OE_EN
    .miso_oe    (miso_oe),
`endif
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rise_cyc = 0;

  // Scoreboard state.
  logic [7:0] rx_q[$];
  logic [7:0] pend[$];
  logic [7:0] last_rx = 8'h00;
  int und_cnt  = 0;
  int und_exp  = 0;
  int ferr_cnt = 0;
  int ferr_exp = 0;

  // Per-frame stimulus description.
  logic [7:0] mo_w[4];
  logic [7:0] tx_next[4];
  bit         tx_has[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each rx word against the scoreboard queue and counts status pulses.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_valid) begin
        check("rx_pending", rx_q.size() > 0, 1);
        if (rx_q.size() > 0) check("rx_data", rx_data, rx_q.pop_front());
        check("rx_latency", cyc - last_rise_cyc, SYNC + 1);
      end
      if (frame_err)   ferr_cnt++;
      if (tx_underrun) und_cnt++;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_miso"},        miso, 0);
    check({tag, "_tx_ready"},    tx_ready, 1);
    check({tag, "_rx_data"},     rx_data, 0);
    check({tag, "_rx_valid"},    rx_valid, 0);
    check({tag, "_busy"},        busy, 0);
    check({tag, "_frame_err"},   frame_err, 0);
    check({tag, "_tx_underrun"}, tx_underrun, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check({tag, "_miso_oe"},     miso_oe, 0);
`endif
  endtask

  // Producer: waits (bounded) for tx_ready, then hands one word over.
  task automatic offer(input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", tx_ready, 1);
    if (tx_ready) begin
      tx_data  = d;
      tx_valid = 1'b1;
      pend.push_back(d);
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  // Reference for a word slot: oldest offered word, or zeros plus an underrun.
  task automatic next_load(output logic [7:0] w);
    if (pend.size() > 0) begin
      w = pend.pop_front();
    end else begin
      w = 8'h00;
      und_exp++;
    end
  endtask

  // Master: nwords back-to-back words, or a frame cut after 'cut' rising edges.
  // The final sclk fall coincides with cs_n rising, so it never triggers a load.
  task automatic run_frame(input int nwords, input int half, input int cut);
    logic [7:0] exp_tx[4];
    logic [7:0] got[4];
    int total;
    int w;
    int b;
    total = (cut != 0) ? cut : nwords * 8;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = mo_w[0][7];
    next_load(exp_tx[0]);
    repeat (half) @(negedge clk);
    check("tx_ready_after_cs_fall", tx_ready, 1);
    check("busy_in_frame", busy, 1);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("miso_oe_in_frame", miso_oe, 1);
`endif
    for (int r = 0; r < total; r++) begin
      w = r / 8;
      b = r % 8;
      if (b == 0 && cut == 0 && w < nwords - 1 && tx_has[w+1]) offer(tx_next[w+1]);
      got[w][7-b] = miso;
      sclk = 1'b1;
      last_rise_cyc = cyc;
      if (b == 7) begin
        rx_q.push_back(mo_w[w]);
        last_rx = mo_w[w];
      end
      repeat (half) @(negedge clk);
      sclk = 1'b0;
      if (r == total - 1) begin
        cs_n = 1'b1;
      end else begin
        mosi = mo_w[(r+1)/8][7-((r+1)%8)];
        if (b == 7) next_load(exp_tx[w+1]);
      end
      repeat (half) @(negedge clk);
    end
    if (cut != 0) ferr_exp++;
    else for (int i = 0; i < nwords; i++) check("miso_word", got[i], exp_tx[i]);
    repeat (half + 6) @(negedge clk);
    check("busy_after_frame", busy, 0);
    check("miso_after_frame", miso, 0);
    check("rx_data_held", rx_data, last_rx);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("miso_oe_after_frame", miso_oe, 0);
`endif
  endtask

  // Bound on total run time.
  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: still running at cycle %0d, required finish before 80000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int und_before;
    int nw;
    int half;
    int cut;
    logic [7:0] tmp;

    foreach (tx_has[i]) tx_has[i] = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single word: tx 0xA5, rx 0x3C.
    offer(8'hA5);
    check("tx_ready_full", tx_ready, 0);
    mo_w[0] = 8'h3C;
    run_frame(1, 10, 0);
    check("underrun_single", und_cnt, und_exp);

    // Back-to-back: tx 0x81 then 0x7E, rx 0x11 then 0x22.
    offer(8'h81);
    mo_w[0] = 8'h11;
    mo_w[1] = 8'h22;
    tx_has[1]  = 1'b1;
    tx_next[1] = 8'h7E;
    und_before = und_cnt;
    run_frame(2, 10, 0);
    tx_has[1] = 1'b0;
    check("underrun_b2b", und_cnt - und_before, 0);

    // Underrun: nothing offered, rx 0xF0.
    mo_w[0] = 8'hF0;
    und_before = und_cnt;
    run_frame(1, 8, 0);
    check("underrun_empty", und_cnt - und_before, 1);
    check("underrun_model", und_cnt, und_exp);

    // Aborted frame after 5 rising edges, then a good frame.
    mo_w[0] = 8'($urandom);
    run_frame(1, 6, 5);
    check("frame_err_abort", ferr_cnt, ferr_exp);
    offer(8'($urandom));
    mo_w[0] = 8'($urandom);
    run_frame(1, 6, 0);

    // Async reset mid-frame after 3 bits.
    mo_w[0] = 8'hC6;
    @(negedge clk);
    cs_n = 1'b0;
    mosi = mo_w[0][7];
    next_load(tmp);
    repeat (6) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      sclk = 1'b1;
      repeat (6) @(negedge clk);
      sclk = 1'b0;
      mosi = mo_w[0][6-r];
      repeat (6) @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("midreset_hold");
    reset_n = 1'b1;
    last_rx = 8'h00;
    repeat (10) @(negedge clk);
    check("frame_err_after_reset", ferr_cnt, ferr_exp);
    mo_w[0] = 8'h5A;
    run_frame(1, 8, 0);

    // Randomized frames: 1-3 words, random sclk rate, random tx supply, occasional abort.
    for (int f = 0; f < 25; f++) begin
      nw   = $urandom_range(1, 3);
      half = $urandom_range(4, 12);
      cut  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      if (cut != 0) nw = 1;
      for (int i = 0; i < 4; i++) begin
        mo_w[i]    = 8'($urandom);
        tx_next[i] = 8'($urandom);
        tx_has[i]  = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 1) == 1) offer(8'($urandom));
      run_frame(nw, half, cut);
    end

    repeat (20) @(negedge clk);
    check("rx_queue_drained", rx_q.size(), 0);
    check("underrun_total", und_cnt, und_exp);
    check("frame_err_total", ferr_cnt, ferr_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
